// File: rtl/store_align_unit.sv
// Store alignment unit: formats RV32 SB/SH/SW requests into word-aligned byte-lane
// writes and queues them in a 2-entry FIFO in front of the memory write port.
module store_align_unit (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_st_valid,
  output logic        o_st_ready,
  input  logic [31:0] i_st_addr,
  input  logic [31:0] i_st_data,
  input  logic [2:0]  i_funct3,
  output logic        o_mem_valid,
  input  logic        i_mem_ack,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_wstrb,
  output logic        o_st_err,
  output logic        o_busy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } entry_t;

  state_t state_q, state_d;
  entry_t fifo_q [2];
  entry_t fmt;
  entry_t head;
  logic   fmt_legal;
  logic   wr_ptr_q, rd_ptr_q;
  logic   err_q;
  logic   accept, push, pop;

  // Lane formatting of the incoming request.
  // NOTE: every signal assigned in always_comb gets a default first; a path that
  // leaves one unassigned would otherwise infer a latch.
  always_comb begin
    fmt       = '0;
    fmt_legal = 1'b0;
    fmt.addr  = {i_st_addr[31:2], 2'b00};
    unique case (i_funct3)
      3'b000: begin
        fmt.wdata = {4{i_st_data[7:0]}};
        fmt.wstrb = 4'b0001 << i_st_addr[1:0];
        fmt_legal = 1'b1;
      end
      3'b001: begin
        fmt.wdata = {2{i_st_data[15:0]}};
        fmt.wstrb = i_st_addr[1] ? 4'b1100 : 4'b0011;
        fmt_legal = ~i_st_addr[0];
      end
      3'b010: begin
        fmt.wdata = i_st_data;
        fmt.wstrb = 4'b1111;
        fmt_legal = (i_st_addr[1:0] == 2'b00);
      end
      default: fmt_legal = 1'b0;
    endcase
  end

  // Ready depends only on the state register, never on i_mem_ack.
  assign o_st_ready  = (state_q != FULL);
  assign o_mem_valid = (state_q != EMPTY);
  assign o_busy      = (state_q != EMPTY);
  assign accept      = i_st_valid & o_st_ready;
  assign push        = accept & fmt_legal;
  assign pop         = o_mem_valid & i_mem_ack;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (push) state_d = ONE;
      ONE: begin
        if (push && !pop)      state_d = FULL;
        else if (pop && !push) state_d = EMPTY;
      end
      FULL:    if (pop) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= EMPTY;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= accept & ~fmt_legal;
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
    end
  end

  // NOTE: the storage array is not reset; its contents are only observable
  // through the valid-gated head below, so clearing it would buy nothing.
  always_ff @(posedge i_clk) begin
    if (push) fifo_q[wr_ptr_q] <= fmt;
  end

  assign head        = o_mem_valid ? fifo_q[rd_ptr_q] : '0;
  assign o_mem_addr  = head.addr;
  assign o_mem_wdata = head.wdata;
  assign o_mem_wstrb = head.wstrb;
  assign o_st_err    = err_q;

endmodule
